// File: rtl/carrier_wipeoff_accum.sv
// Carrier wipe-off and saturating integrate-and-dump of 2-bit sign/magnitude samples against 1-bit I/Q LO.
// Result appears 1 clk after the len-th valid sample; an unconsumed result is overwritten and flagged in overrun.
module carrier_wipeoff_accum #(
    parameter int ACC_W = 16,
    parameter int LEN_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    continuous,
    input  logic                    abort,
    input  logic [LEN_W-1:0]        len,
    input  logic                    sample_valid,
    input  logic                    sample_sign,
    input  logic                    sample_mag,
    input  logic                    lo_i,
    input  logic                    lo_q,
    output logic                    busy,
    output logic signed [ACC_W-1:0] acc_i,
    output logic signed [ACC_W-1:0] acc_q,
    output logic                    res_sat,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    overrun
);

    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_INTEGRATE = 1'b1
    } state_t;

    localparam logic signed [ACC_W-1:0] MAX_V = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = {1'b1, {(ACC_W-1){1'b0}}};

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [LEN_W-1:0]        r_len;
    logic [LEN_W-1:0]        r_cnt;
    logic signed [ACC_W-1:0] r_acc_i;
    logic signed [ACC_W-1:0] r_acc_q;
    logic                    r_sat;

    logic signed [2:0]       w_mag;
    logic signed [2:0]       w_s;
    logic signed [2:0]       w_p_i;
    logic signed [2:0]       w_p_q;
    logic signed [ACC_W:0]   w_sum_i;
    logic signed [ACC_W:0]   w_sum_q;
    logic signed [ACC_W-1:0] w_nxt_i;
    logic signed [ACC_W-1:0] w_nxt_q;
    logic                    w_clip_i;
    logic                    w_clip_q;
    logic [LEN_W:0]          w_cnt_nxt;
    logic                    w_arm;
    logic                    w_take;
    logic                    w_last;
    logic                    w_dump;

    assign busy = (r_state == ST_INTEGRATE);

    // Mixer and one-bit-wider sum; overflow shows as a disagreement of the top two bits.
    always_comb begin
        w_mag    = sample_mag ? 3'sd3 : 3'sd1;
        w_s      = sample_sign ? -w_mag : w_mag;
        w_p_i    = lo_i ? w_s : -w_s;
        w_p_q    = lo_q ? w_s : -w_s;
        w_sum_i  = {r_acc_i[ACC_W-1], r_acc_i} + {{(ACC_W-2){w_p_i[2]}}, w_p_i};
        w_sum_q  = {r_acc_q[ACC_W-1], r_acc_q} + {{(ACC_W-2){w_p_q[2]}}, w_p_q};
        w_clip_i = (w_sum_i[ACC_W] != w_sum_i[ACC_W-1]);
        w_clip_q = (w_sum_q[ACC_W] != w_sum_q[ACC_W-1]);
        w_nxt_i  = w_clip_i ? (w_sum_i[ACC_W] ? MIN_V : MAX_V) : w_sum_i[ACC_W-1:0];
        w_nxt_q  = w_clip_q ? (w_sum_q[ACC_W] ? MIN_V : MAX_V) : w_sum_q[ACC_W-1:0];
    end

    assign w_cnt_nxt = {1'b0, r_cnt} + {{LEN_W{1'b0}}, 1'b1};
    assign w_arm     = (r_state == ST_IDLE) && start && (len != '0);
    assign w_take    = (r_state == ST_INTEGRATE) && !abort && sample_valid;
    assign w_last    = (w_cnt_nxt == {1'b0, r_len});
    assign w_dump    = w_take && w_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_arm) begin
                    w_state_nxt = ST_INTEGRATE;
                end
            end
            ST_INTEGRATE: begin
                if (abort || (w_dump && !continuous)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_len     <= '0;
            r_cnt     <= '0;
            r_acc_i   <= '0;
            r_acc_q   <= '0;
            r_sat     <= 1'b0;
            acc_i     <= '0;
            acc_q     <= '0;
            res_sat   <= 1'b0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (w_arm) begin
                r_len   <= len;
                r_cnt   <= '0;
                r_acc_i <= '0;
                r_acc_q <= '0;
                r_sat   <= 1'b0;
                overrun <= 1'b0;
            end else if ((r_state == ST_INTEGRATE) && abort) begin
                r_cnt   <= '0;
                r_acc_i <= '0;
                r_acc_q <= '0;
                r_sat   <= 1'b0;
            end else if (w_dump) begin
                acc_i   <= w_nxt_i;
                acc_q   <= w_nxt_q;
                res_sat <= r_sat | w_clip_i | w_clip_q;
                r_cnt   <= '0;
                r_acc_i <= '0;
                r_acc_q <= '0;
                r_sat   <= 1'b0;
            end else if (w_take) begin
                r_cnt   <= w_cnt_nxt[LEN_W-1:0];
                r_acc_i <= w_nxt_i;
                r_acc_q <= w_nxt_q;
                r_sat   <= r_sat | w_clip_i | w_clip_q;
            end

            // A dump landing on a pending, unaccepted result loses that result.
            if (w_dump) begin
                out_valid <= 1'b1;
                if (out_valid && !out_ready) begin
                    overrun <= 1'b1;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_carrier_wipeoff_accum.sv
// Bench for carrier_wipeoff_accum: a 16-bit and an 8-bit instance share stimulus; a cycle model feeds a result scoreboard.
module tb_carrier_wipeoff_accum;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic continuous = 1'b0;
    logic abort = 1'b0;
    logic [15:0] len = 16'd0;
    logic sample_valid = 1'b0;
    logic sample_sign = 1'b0;
    logic sample_mag = 1'b0;
    logic lo_i = 1'b0;
    logic lo_q = 1'b0;
    logic out_ready = 1'b0;

    logic busy, res_sat, out_valid, overrun;
    logic signed [15:0] acc_i, acc_q;
    logic busy8, res_sat8, out_valid8, overrun8;
    logic signed [7:0] acc_i8, acc_q8;

    typedef struct {
        int i16; int q16; bit s16;
        int i8;  int q8;  bit s8;
    } res_t;

    res_t exp_q[$];
    res_t cur;

    int checks = 0;
    int errors = 0;

    bit m_busy, m_ov, m_ovr, m_s16, m_s8;
    int m_len, m_cnt, m_i16, m_q16, m_i8, m_q8;

    carrier_wipeoff_accum #(.ACC_W(16), .LEN_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous), .abort(abort),
        .len(len), .sample_valid(sample_valid), .sample_sign(sample_sign),
        .sample_mag(sample_mag), .lo_i(lo_i), .lo_q(lo_q), .busy(busy),
        .acc_i(acc_i), .acc_q(acc_q), .res_sat(res_sat), .out_valid(out_valid),
        .out_ready(out_ready), .overrun(overrun)
    );

    carrier_wipeoff_accum #(.ACC_W(8), .LEN_W(16)) dut8 (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous), .abort(abort),
        .len(len), .sample_valid(sample_valid), .sample_sign(sample_sign),
        .sample_mag(sample_mag), .lo_i(lo_i), .lo_q(lo_q), .busy(busy8),
        .acc_i(acc_i8), .acc_q(acc_q8), .res_sat(res_sat8), .out_valid(out_valid8),
        .out_ready(out_ready), .overrun(overrun8)
    );

    always #5 clk = ~clk;

    function automatic int clampw(input int v, input int w);
        int lo, hi;
        lo = -(1 <<< (w - 1));
        hi = (1 <<< (w - 1)) - 1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    task automatic model_clear();
        m_i16 = 0; m_q16 = 0; m_s16 = 0;
        m_i8 = 0;  m_q8 = 0;  m_s8 = 0;
        m_cnt = 0;
    endtask

    // One clock: advance the model from the driven inputs, clock, then compare both instances.
    task automatic step();
        bit dump;
        int s, pi, pq, t;
        res_t r;
        dump = 0;
        if (rst) begin
            m_busy = 0; m_ov = 0; m_ovr = 0;
            model_clear();
            exp_q.delete();
            cur = '{0, 0, 0, 0, 0, 0};
        end else begin
            if (!m_busy) begin
                if (start && len != 16'd0) begin
                    m_busy = 1; m_len = int'(len); m_ovr = 0;
                    model_clear();
                end
            end else if (abort) begin
                m_busy = 0;
                model_clear();
            end else if (sample_valid) begin
                s = sample_mag ? 3 : 1;
                if (sample_sign) s = -s;
                pi = lo_i ? s : -s;
                pq = lo_q ? s : -s;
                t = clampw(m_i16 + pi, 16); if (t != m_i16 + pi) m_s16 = 1; m_i16 = t;
                t = clampw(m_q16 + pq, 16); if (t != m_q16 + pq) m_s16 = 1; m_q16 = t;
                t = clampw(m_i8 + pi, 8);   if (t != m_i8 + pi)  m_s8 = 1;  m_i8 = t;
                t = clampw(m_q8 + pq, 8);   if (t != m_q8 + pq)  m_s8 = 1;  m_q8 = t;
                m_cnt++;
                if (m_cnt == m_len) begin
                    dump = 1;
                    r = '{m_i16, m_q16, m_s16, m_i8, m_q8, m_s8};
                    exp_q.push_back(r);
                    model_clear();
                    if (!continuous) m_busy = 0;
                end
            end
            if (dump) begin
                if (m_ov && !out_ready) m_ovr = 1;
                m_ov = 1;
            end else if (m_ov && out_ready) begin
                m_ov = 0;
            end
        end

        @(posedge clk);
        #1;

        if (dump) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty: dump expected but no queued result");
            end else begin
                cur = exp_q.pop_front();
            end
        end
        checks++; if (busy !== m_busy)       begin errors++; $display("FAIL busy: got %b want %b", busy, m_busy); end
        checks++; if (out_valid !== m_ov)    begin errors++; $display("FAIL out_valid: got %b want %b", out_valid, m_ov); end
        checks++; if (overrun !== m_ovr)     begin errors++; $display("FAIL overrun: got %b want %b", overrun, m_ovr); end
        checks++; if (int'(acc_i) !== cur.i16) begin errors++; $display("FAIL acc_i: got %0d want %0d", acc_i, cur.i16); end
        checks++; if (int'(acc_q) !== cur.q16) begin errors++; $display("FAIL acc_q: got %0d want %0d", acc_q, cur.q16); end
        checks++; if (res_sat !== cur.s16)   begin errors++; $display("FAIL res_sat: got %b want %b", res_sat, cur.s16); end
        checks++; if (busy8 !== m_busy)      begin errors++; $display("FAIL busy8: got %b want %b", busy8, m_busy); end
        checks++; if (out_valid8 !== m_ov)   begin errors++; $display("FAIL out_valid8: got %b want %b", out_valid8, m_ov); end
        checks++; if (overrun8 !== m_ovr)    begin errors++; $display("FAIL overrun8: got %b want %b", overrun8, m_ovr); end
        checks++; if (int'(acc_i8) !== cur.i8) begin errors++; $display("FAIL acc_i8: got %0d want %0d", acc_i8, cur.i8); end
        checks++; if (int'(acc_q8) !== cur.q8) begin errors++; $display("FAIL acc_q8: got %0d want %0d", acc_q8, cur.q8); end
        checks++; if (res_sat8 !== cur.s8)   begin errors++; $display("FAIL res_sat8: got %b want %b", res_sat8, cur.s8); end
    endtask

    task automatic do_start(input int n);
        start = 1'b1;
        len = n[15:0];
        step();
        start = 1'b0;
    endtask

    task automatic smp(input bit sg, input bit mg, input bit li, input bit lq);
        sample_sign = sg; sample_mag = mg; lo_i = li; lo_q = lq;
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || overrun !== 1'b0 || acc_i !== 16'sd0)
            begin errors++; $display("FAIL reset_state: busy=%b out_valid=%b overrun=%b acc_i=%0d want all 0", busy, out_valid, overrun, acc_i); end
    endtask

    task automatic test_basic();
        out_ready = 1'b0; continuous = 1'b0;
        do_start(4);
        for (int k = 0; k < 4; k++) smp(1'b0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (acc_i !== 16'sd12 || acc_q !== -16'sd12 || out_valid !== 1'b1 || busy !== 1'b0)
            begin errors++; $display("FAIL basic_result: acc_i=%0d acc_q=%0d ov=%b busy=%b want 12 -12 1 0", acc_i, acc_q, out_valid, busy); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_consume: out_valid=%b want 0", out_valid); end
    endtask

    task automatic test_gapped();
        do_start(3);
        smp(1'b0, 1'b0, 1'b1, 1'b1);
        step();
        smp(1'b1, 1'b1, 1'b1, 1'b1);
        step();
        step();
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL gapped_mid: busy=%b ov=%b want 1 0", busy, out_valid); end
        smp(1'b0, 1'b1, 1'b1, 1'b1);
        checks++;
        if (acc_i !== 16'sd1 || acc_q !== 16'sd1 || out_valid !== 1'b1)
            begin errors++; $display("FAIL gapped_result: acc_i=%0d acc_q=%0d ov=%b want 1 1 1", acc_i, acc_q, out_valid); end
        out_ready = 1'b1; step(); out_ready = 1'b0;
    endtask

    task automatic test_continuous();
        out_ready = 1'b0; continuous = 1'b1;
        do_start(2);
        smp(1'b0, 1'b0, 1'b1, 1'b1);
        smp(1'b0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (acc_i !== 16'sd2 || busy !== 1'b1 || overrun !== 1'b0)
            begin errors++; $display("FAIL cont_first: acc_i=%0d busy=%b overrun=%b want 2 1 0", acc_i, busy, overrun); end
        smp(1'b0, 1'b0, 1'b1, 1'b1);
        smp(1'b0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (overrun !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("FAIL cont_overrun: overrun=%b ov=%b want 1 1", overrun, out_valid); end
        continuous = 1'b0;
        abort = 1'b1; step(); abort = 1'b0;
        do_start(1);
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL start_clears_overrun: overrun=%b want 0", overrun); end
        smp(1'b1, 1'b0, 1'b0, 1'b1);
        out_ready = 1'b1; step(); out_ready = 1'b0;
    endtask

    task automatic test_saturation();
        do_start(50);
        for (int k = 0; k < 50; k++) smp(1'b0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (acc_i8 !== 8'sd127 || acc_q8 !== -8'sd128 || res_sat8 !== 1'b1)
            begin errors++; $display("FAIL sat8_result: acc_i=%0d acc_q=%0d sat=%b want 127 -128 1", acc_i8, acc_q8, res_sat8); end
        checks++;
        if (acc_i !== 16'sd150 || acc_q !== -16'sd150 || res_sat !== 1'b0)
            begin errors++; $display("FAIL sat16_result: acc_i=%0d acc_q=%0d sat=%b want 150 -150 0", acc_i, acc_q, res_sat); end
    endtask

    task automatic test_abort_reset();
        do_start(4);
        smp(1'b0, 1'b0, 1'b1, 1'b1);
        smp(1'b0, 1'b0, 1'b1, 1'b1);
        abort = 1'b1; step(); abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b1 || acc_i !== 16'sd150)
            begin errors++; $display("FAIL abort_state: busy=%b ov=%b acc_i=%0d want 0 1 150", busy, out_valid, acc_i); end
        abort = 1'b1; step(); abort = 1'b0;
        do_start(4);
        for (int k = 0; k < 4; k++) smp(1'b0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (acc_i !== 16'sd4 || acc_q !== 16'sd4) begin errors++; $display("FAIL abort_restart: acc_i=%0d acc_q=%0d want 4 4", acc_i, acc_q); end
        do_start(4);
        smp(1'b0, 1'b1, 1'b1, 1'b1);
        smp(1'b0, 1'b1, 1'b1, 1'b1);
        rst = 1'b1; step(); rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || overrun !== 1'b0 || acc_i !== 16'sd0 || acc_q !== 16'sd0 || res_sat !== 1'b0)
            begin errors++; $display("FAIL reset_mid: busy=%b ov=%b ovr=%b acc_i=%0d acc_q=%0d sat=%b want all 0", busy, out_valid, overrun, acc_i, acc_q, res_sat); end
    endtask

    task automatic test_edge();
        do_start(0);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL len0_start: busy=%b want 0", busy); end
        do_start(1);
        smp(1'b0, 1'b0, 1'b1, 1'b1);
        do_start(1);
        out_ready = 1'b1;
        smp(1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || overrun !== 1'b0 || acc_i !== -16'sd3 || acc_q !== 16'sd3)
            begin errors++; $display("FAIL dump_and_consume: ov=%b ovr=%b acc_i=%0d acc_q=%0d want 1 0 -3 3", out_valid, overrun, acc_i, acc_q); end
        do_start(2);
        start = 1'b1; len = 16'd5;
        smp(1'b0, 1'b0, 1'b0, 1'b0);
        start = 1'b0;
        smp(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b1 || acc_i !== -16'sd2)
            begin errors++; $display("FAIL start_while_busy: busy=%b ov=%b acc_i=%0d want 0 1 -2", busy, out_valid, acc_i); end
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gapped();
        test_continuous();
        test_saturation();
        test_abort_reset();
        test_edge();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover: %0d results never produced", exp_q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
